// File: rtl/led_fader_pkg.sv
// led_fader_pkg: shared constants and helpers for the LED fader.
// Optional feature macro: LED_FADER_GAMMA_EN (square-law duty curve).
package led_fader_pkg;

   localparam int unsigned LED_COUNT        = 4;
   localparam int unsigned DEF_PWM_BITS     = 8;
   localparam int unsigned DEF_DECAY_PERIOD = 65536;
   localparam int unsigned DEF_DECAY_STEP   = 8;

   // Full-brightness level for a given level width.
   function automatic int unsigned level_max(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/led_fader_channel.sv
// led_fader_channel: one LED's brightness level, duty mapping and PWM output.
// Optional feature macro: LED_FADER_GAMMA_EN selects a square-law duty curve.
module led_fader_channel
   import led_fader_pkg::*;
#(
   parameter int unsigned PWM_BITS   = DEF_PWM_BITS,
   parameter int unsigned DECAY_STEP = DEF_DECAY_STEP
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                data_in,
   input  logic                tick,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   output logic                led_out
);

   localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(level_max(PWM_BITS));

   logic [PWM_BITS-1:0] level;
   logic [PWM_BITS-1:0] duty;

`ifdef LED_FADER_GAMMA_EN
   logic [2*PWM_BITS-1:0] level_sq;

   // Square-law curve: keep the upper half of level^2.
   always_comb begin
      level_sq = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level};
      duty     = level_sq[2*PWM_BITS-1:PWM_BITS];
   end
`else
   // Linear curve: duty tracks level directly.
   always_comb begin
      duty = level;
   end
`endif

   // Level: a lit input pins full brightness; otherwise saturating decay on tick.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         level <= '0;
      end else if (data_in) begin
         level <= MAX;
      end else if (tick) begin
         if (32'(level) > DECAY_STEP)
            level <= level - PWM_BITS'(DECAY_STEP);
         else
            level <= '0;
      end
   end

   // Registered PWM compare; MAX forces solid on so there is no off cycle per period.
   always_ff @(posedge clk_in) begin
      if (rst_in)
         led_out <= 1'b0;
      else
         led_out <= (level == MAX) || (pwm_cnt < duty);
   end

endmodule

// File: rtl/led_fader.sv
// led_fader: per-LED PWM with a linearly decaying trail behind the lit LED.
// Shared PWM phase and decay tick counters feed LED_COUNT independent channels.
// Optional feature macro: LED_FADER_GAMMA_EN (square-law duty curve in channels).
module led_fader
   import led_fader_pkg::*;
#(
   parameter int unsigned PWM_BITS     = DEF_PWM_BITS,
   parameter int unsigned DECAY_PERIOD = DEF_DECAY_PERIOD,
   parameter int unsigned DECAY_STEP   = DEF_DECAY_STEP
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic [LED_COUNT-1:0] data_in,
   output logic [LED_COUNT-1:0] led_out
);

   // A period of 1 still needs a 1-bit counter; it simply never leaves 0.
   localparam int unsigned    TW        = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
   localparam logic [TW-1:0]  TICK_LAST = TW'(DECAY_PERIOD - 1);

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [TW-1:0]       tick_cnt;
   logic                tick;

   assign tick = (tick_cnt == TICK_LAST);

   // Free-running PWM phase and decay prescaler, both restarted by reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pwm_cnt  <= '0;
         tick_cnt <= '0;
      end else begin
         pwm_cnt  <= pwm_cnt + 1'b1;
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < LED_COUNT; i++) begin : g_ch
      led_fader_channel #(
         .PWM_BITS   (PWM_BITS),
         .DECAY_STEP (DECAY_STEP)
      ) u_ch (
         .clk_in  (clk_in),
         .rst_in  (rst_in),
         .data_in (data_in[i]),
         .tick    (tick),
         .pwm_cnt (pwm_cnt),
         .led_out (led_out[i])
      );
   end

endmodule
